if_fetch_buf: RTL and testbench



---
 rtl/if_pkg.sv | 27 ++
 rtl/if_fetch_buf_if.sv | 42 ++++
 rtl/if_fifo.sv | 49 ++++
 rtl/if_fetch_buf.sv | 113 +++++++++++
 tb/tb_if_fetch_buf.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: fetch FSM state enum (2-bit), default substitute instruction,
// fetch entry layout {pc, inst, misalign} at the default 32/32 widths.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2,
    DRAIN    = 2'd3
  } fetch_state_e;

  localparam int unsigned ENTRY_ADDR_W = 32;
  localparam int unsigned ENTRY_DATA_W = 32;

  // Instruction delivered in place of a misaligned fetch.
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] pc;
    logic [ENTRY_DATA_W-1:0] inst;
    logic                    misalign;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_buf_if.sv
// Fetch-stage bus bundle: PC register side, instruction memory side, decode side.
// Latency: n/a (wiring only).
// Backpressure: pc_stall toward the PC register, id_ready from decode.
// Modports: master = fetch buffer, slave = its environment (PC reg, memory, decode).
// Optional id_misalign exists only when FETCH_ALIGN_CHECK_EN is defined.
interface if_fetch_buf_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] pc;
  logic              ce;
  logic              pc_stall;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              flush;
  logic              id_valid;
  logic              id_ready;
  logic [ADDR_W-1:0] id_pc;
  logic [DATA_W-1:0] id_inst;
`ifdef FETCH_ALIGN_CHECK_EN
  logic              id_misalign;
`endif

  modport master (
    input  pc, ce, imem_gnt, imem_rvalid, imem_rdata, flush, id_ready,
    output pc_stall, imem_req, imem_addr, id_valid, id_pc, id_inst
`ifdef FETCH_ALIGN_CHECK_EN
    , output id_misalign
`endif
  );

  modport slave (
    output pc, ce, imem_gnt, imem_rvalid, imem_rdata, flush, id_ready,
    input  pc_stall, imem_req, imem_addr, id_valid, id_pc, id_inst
`ifdef FETCH_ALIGN_CHECK_EN
    , input id_misalign
`endif
  );
endinterface

// File: rtl/if_fifo.sv
// DEPTH-entry synchronous FIFO holding fetched entries; head read from registers.
// Latency: push at edge N visible at head at N+1 when empty.
// Backpressure: none internally; caller must not push when full. clear overrides push/pop.
// Ports: clk, rst (async high), push/din, pop, clear, count, head.
module if_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_buf.sv
// Instruction fetch: one outstanding imem request, {pc,inst} buffered for decode.
// Latency: launch -> gnt -> rvalid; rvalid at edge N gives id_valid at N+1 (empty FIFO).
// Backpressure: pc_stall holds the PC unless a fetch launches; launch needs a free FIFO slot.
// Ports: clk, rst (async high), bus (if_fetch_buf_if.master): pc/ce/pc_stall,
// imem_req/addr/gnt/rvalid/rdata, flush, id_valid/ready/pc/inst.
// Optional FETCH_ALIGN_CHECK_EN: misaligned pc pushes NOP_INST with id_misalign=1, no request.
module if_fetch_buf
  import if_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
`ifdef FETCH_ALIGN_CHECK_EN
  , parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP_INST_DEF)
`endif
) (
  input  logic           clk,
  input  logic           rst,
  if_fetch_buf_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam int ENTRY_W = ADDR_W + DATA_W + 1;
`else
  localparam int ENTRY_W = ADDR_W + DATA_W;
`endif

  fetch_state_e       state;
  logic [CW-1:0]      count;
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] push_dat;
  logic               launch;
  logic               req_launch;
  logic               rsp_push;
  logic               fifo_push;
  logic               fifo_pop;

  // Credit is judged on the current count only; a same-cycle pop is not counted.
  assign launch   = (state == IDLE) && bus.ce && (count < CW'(DEPTH)) && !bus.flush;
  assign bus.pc_stall = rst | ~launch;
  assign rsp_push = (state == WAIT_RSP) && bus.imem_rvalid && !bus.flush;
  assign fifo_pop = bus.id_valid && bus.id_ready;

`ifdef FETCH_ALIGN_CHECK_EN
  logic mis_launch;
  assign mis_launch = launch && (bus.pc[1:0] != 2'b00);
  assign req_launch = launch && !mis_launch;
  assign fifo_push  = rsp_push | mis_launch;
  assign push_dat   = mis_launch ? {bus.pc, NOP_INST, 1'b1}
                                 : {bus.imem_addr, bus.imem_rdata, 1'b0};
  assign bus.id_misalign = head[0];
`else
  assign req_launch = launch;
  assign fifo_push  = rsp_push;
  assign push_dat   = {bus.imem_addr, bus.imem_rdata};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.imem_req  <= 1'b0;
      bus.imem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_launch) begin
            bus.imem_addr <= bus.pc;
            bus.imem_req  <= 1'b1;
            state         <= WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          if (bus.imem_gnt) begin
            // A granted request always returns data, so a flush here must drain it.
            bus.imem_req <= 1'b0;
            state        <= bus.flush ? DRAIN : WAIT_RSP;
          end else if (bus.flush) begin
            bus.imem_req <= 1'b0;
            state        <= IDLE;
          end
        end
        WAIT_RSP: begin
          if (bus.imem_rvalid)   state <= IDLE;
          else if (bus.flush)    state <= DRAIN;
        end
        DRAIN: begin
          if (bus.imem_rvalid)   state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  if_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (push_dat),
    .pop   (fifo_pop),
    .clear (bus.flush),
    .count (count),
    .head  (head)
  );

  assign bus.id_valid = (count != '0);
  assign bus.id_pc    = head[ENTRY_W-1 -: ADDR_W];
  assign bus.id_inst  = head[ENTRY_W-ADDR_W-1 -: DATA_W];

endmodule

// File: tb/tb_if_fetch_buf.sv
// Testbench for if_fetch_buf: directed table, corner-case sequences, random vs queue model.
module tb_if_fetch_buf;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  if_fetch_buf_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  if_fetch_buf #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        ce;
    logic [31:0] pc;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        fl;
    logic        rdy;
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] idpc;
    logic [31:0] idinst;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ce, input logic [31:0] pc, input logic gnt, input logic rv,
                       input logic [31:0] rdata, input logic fl, input logic rdy);
    bus.ce          = ce;
    bus.pc          = pc;
    bus.imem_gnt    = gnt;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rdata;
    bus.flush       = fl;
    bus.id_ready    = rdy;
  endtask

  function automatic vec_t mk(input logic ce, input logic [31:0] pc, input logic gnt,
                              input logic rv, input logic [31:0] rdata, input logic fl,
                              input logic rdy, input logic stall, input logic req,
                              input logic [31:0] addr, input logic vld,
                              input logic [31:0] idpc, input logic [31:0] idinst);
    vec_t v;
    v.ce = ce; v.pc = pc; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.fl = fl; v.rdy = rdy;
    v.stall = stall; v.req = req; v.addr = addr; v.vld = vld; v.idpc = idpc; v.idinst = idinst;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model state: offered request, outstanding response, kill flag, entry queue.
  logic        m_req, m_wait, m_kill;
  logic [31:0] m_addr;
  ent_t        m_q [$];

  initial begin
    // Inputs applied at negedge, outputs sampled 1 time unit later, state moves at posedge.
    tbl[0]  = mk(1, 32'h0,  0, 0, 32'h0,        0, 0,  0, 0, 32'h0, 0, 32'h0, 32'h0);
    tbl[1]  = mk(1, 32'h4,  1, 0, 32'h0,        0, 0,  1, 1, 32'h0, 0, 32'h0, 32'h0);
    tbl[2]  = mk(1, 32'h4,  0, 0, 32'h0,        0, 0,  1, 0, 32'h0, 0, 32'h0, 32'h0);
    tbl[3]  = mk(1, 32'h4,  0, 1, 32'h8C010004, 0, 0,  1, 0, 32'h0, 0, 32'h0, 32'h0);
    tbl[4]  = mk(1, 32'h4,  0, 0, 32'h0,        0, 0,  0, 0, 32'h0, 1, 32'h0, 32'h8C010004);
    tbl[5]  = mk(1, 32'h8,  1, 0, 32'h0,        0, 0,  1, 1, 32'h4, 1, 32'h0, 32'h8C010004);
    tbl[6]  = mk(1, 32'h8,  0, 1, 32'h11111111, 0, 0,  1, 0, 32'h4, 1, 32'h0, 32'h8C010004);
    tbl[7]  = mk(1, 32'h8,  0, 0, 32'h0,        0, 0,  1, 0, 32'h4, 1, 32'h0, 32'h8C010004);
    tbl[8]  = mk(1, 32'h8,  0, 0, 32'h0,        0, 0,  1, 0, 32'h4, 1, 32'h0, 32'h8C010004);
    tbl[9]  = mk(1, 32'h8,  0, 0, 32'h0,        0, 1,  1, 0, 32'h4, 1, 32'h0, 32'h8C010004);
    tbl[10] = mk(1, 32'h8,  0, 0, 32'h0,        0, 0,  0, 0, 32'h4, 1, 32'h4, 32'h11111111);
    tbl[11] = mk(1, 32'hC,  1, 0, 32'h0,        0, 0,  1, 1, 32'h8, 1, 32'h4, 32'h11111111);
    tbl[12] = mk(1, 32'hC,  0, 1, 32'h22222222, 0, 1,  1, 0, 32'h8, 1, 32'h4, 32'h11111111);
    tbl[13] = mk(1, 32'hC,  0, 0, 32'h0,        0, 0,  0, 0, 32'h8, 1, 32'h8, 32'h22222222);
    tbl[14] = mk(1, 32'h10, 1, 0, 32'h0,        0, 0,  1, 1, 32'hC, 1, 32'h8, 32'h22222222);
    tbl[15] = mk(1, 32'h10, 0, 1, 32'h33333333, 0, 0,  1, 0, 32'hC, 1, 32'h8, 32'h22222222);
    tbl[16] = mk(1, 32'h10, 0, 0, 32'h0,        0, 1,  1, 0, 32'hC, 1, 32'h8, 32'h22222222);
    tbl[17] = mk(0, 32'h10, 0, 0, 32'h0,        0, 1,  1, 0, 32'hC, 1, 32'hC, 32'h33333333);
    tbl[18] = mk(0, 32'h10, 0, 0, 32'h0,        0, 0,  1, 0, 32'hC, 0, 32'h0, 32'h0);

    // Reset values, with ce high to show pc_stall is forced during reset.
    rst = 1'b1;
    drive(1, 32'h0, 0, 0, 32'h0, 0, 0);
    #1;
    chk("rst.pc_stall",  bus.pc_stall,  1);
    chk("rst.imem_req",  bus.imem_req,  0);
    chk("rst.imem_addr", bus.imem_addr, 0);
    chk("rst.id_valid",  bus.id_valid,  0);
    chk("rst.id_pc",     bus.id_pc,     0);
    chk("rst.id_inst",   bus.id_inst,   0);
    @(negedge clk);
    drive(0, 32'h0, 0, 0, 32'h0, 0, 0);
    rst = 1'b0;

    // Directed table: first fetch, FIFO fill to DEPTH, blocked launch, in-order drain,
    // push and pop in the same cycle.
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(tbl[i].ce, tbl[i].pc, tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].fl, tbl[i].rdy);
      #1;
      chk($sformatf("tbl%0d.pc_stall", i), bus.pc_stall, tbl[i].stall);
      chk($sformatf("tbl%0d.imem_req", i), bus.imem_req, tbl[i].req);
      chk($sformatf("tbl%0d.imem_addr", i), bus.imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d.id_valid", i), bus.id_valid, tbl[i].vld);
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d.id_pc", i), bus.id_pc, tbl[i].idpc);
        chk($sformatf("tbl%0d.id_inst", i), bus.id_inst, tbl[i].idinst);
      end
    end

    // Flush in WAIT_GNT without gnt: request withdrawn, next launch uses redirected pc.
    @(negedge clk); drive(1, 32'h20, 0, 0, 32'h0, 0, 0); #1;
    chk("fgnt.launch_stall", bus.pc_stall, 0);
    @(negedge clk); drive(1, 32'h24, 0, 0, 32'h0, 1, 0); #1;
    chk("fgnt.req_held", bus.imem_req, 1);
    chk("fgnt.addr_held", bus.imem_addr, 32'h20);
    @(negedge clk); drive(1, 32'h40, 0, 0, 32'h0, 0, 0); #1;
    chk("fgnt.req_fell", bus.imem_req, 0);
    chk("fgnt.no_push", bus.id_valid, 0);
    chk("fgnt.relaunch_stall", bus.pc_stall, 0);
    @(negedge clk); drive(1, 32'h44, 1, 0, 32'h0, 0, 0); #1;
    chk("fgnt.new_req", bus.imem_req, 1);
    chk("fgnt.new_addr", bus.imem_addr, 32'h40);
    @(negedge clk); drive(1, 32'h44, 0, 1, 32'hCAFE0040, 0, 0); #1;
    chk("fgnt.req_after_gnt", bus.imem_req, 0);
    @(negedge clk); drive(0, 32'h44, 0, 0, 32'h0, 0, 1); #1;
    chk("fgnt.id_valid", bus.id_valid, 1);
    chk("fgnt.id_pc", bus.id_pc, 32'h40);
    chk("fgnt.id_inst", bus.id_inst, 32'hCAFE0040);
    @(negedge clk); drive(0, 32'h44, 0, 0, 32'h0, 0, 0); #1;
    chk("fgnt.drained", bus.id_valid, 0);

    // Flush together with gnt: DRAIN swallows the late response, then launches resume.
    @(negedge clk); drive(1, 32'h80, 0, 0, 32'h0, 0, 0); #1;
    chk("drain.launch_stall", bus.pc_stall, 0);
    @(negedge clk); drive(1, 32'h84, 1, 0, 32'h0, 1, 0); #1;
    chk("drain.req", bus.imem_req, 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); drive(1, 32'h84, 0, 0, 32'h0, 0, 0); #1;
      chk($sformatf("drain.req_low%0d", k), bus.imem_req, 0);
      chk($sformatf("drain.stall%0d", k), bus.pc_stall, 1);
    end
    @(negedge clk); drive(1, 32'h84, 0, 1, 32'hDEADBEEF, 0, 1); #1;
    chk("drain.stall_rv", bus.pc_stall, 1);
    chk("drain.vld_rv", bus.id_valid, 0);
    @(negedge clk); drive(1, 32'h84, 0, 0, 32'h0, 0, 0); #1;
    chk("drain.discarded", bus.id_valid, 0);
    chk("drain.resume_stall", bus.pc_stall, 0);
    @(negedge clk); drive(1, 32'h88, 0, 0, 32'h0, 1, 0); #1;
    chk("drain.resume_req", bus.imem_req, 1);
    chk("drain.resume_addr", bus.imem_addr, 32'h84);
    @(negedge clk); drive(0, 32'h88, 0, 0, 32'h0, 0, 0); #1;
    chk("drain.withdrawn", bus.imem_req, 0);

    // Reset mid-transaction, then a stray rvalid in IDLE must be ignored.
    @(negedge clk); drive(1, 32'h100, 0, 0, 32'h0, 0, 0);
    @(negedge clk); drive(1, 32'h104, 1, 0, 32'h0, 0, 0);
    @(negedge clk); drive(0, 32'h104, 0, 0, 32'h0, 0, 0); rst = 1'b1; #1;
    chk("rstmid.req", bus.imem_req, 0);
    chk("rstmid.stall", bus.pc_stall, 1);
    @(negedge clk); rst = 1'b0; drive(0, 32'h104, 0, 1, 32'h12345678, 0, 0);
    @(negedge clk); drive(0, 32'h104, 0, 0, 32'h0, 0, 0); #1;
    chk("rstmid.stray_ignored", bus.id_valid, 0);

`ifdef FETCH_ALIGN_CHECK_EN
    @(negedge clk); drive(1, 32'h6, 0, 0, 32'h0, 0, 0); #1;
    chk("mis.stall", bus.pc_stall, 0);
    @(negedge clk); drive(0, 32'h6, 0, 0, 32'h0, 0, 1); #1;
    chk("mis.no_req", bus.imem_req, 0);
    chk("mis.id_valid", bus.id_valid, 1);
    chk("mis.id_pc", bus.id_pc, 32'h6);
    chk("mis.id_inst", bus.id_inst, 32'h0);
    chk("mis.id_misalign", bus.id_misalign, 1);
    @(negedge clk); drive(0, 32'h6, 0, 0, 32'h0, 0, 0); #1;
    chk("mis.popped", bus.id_valid, 0);
`endif

    // Randomized traffic against the transaction-level model. The bench acts as PC
    // register and memory; DUT starts idle with an empty FIFO here.
    m_req = 0; m_wait = 0; m_kill = 0; m_addr = 0;
    m_q.delete();
    begin
      logic [31:0] pc_reg;
      pc_reg = 32'h1000;
      for (int c = 0; c < 3000; c++) begin
        logic ce, gnt, rv, fl, rdy, launch_e, pop_e, push_e, r_old, w_old;
        logic [31:0] rdata;
        ent_t e;
        @(negedge clk);
        fl    = ($urandom_range(0, 15) == 0);
        ce    = ($urandom_range(0, 7) != 0);
        rdy   = $urandom_range(0, 1);
        gnt   = m_req  && ($urandom_range(0, 2) == 0);
        rv    = m_wait && ($urandom_range(0, 2) == 0);
        rdata = $urandom;
        drive(ce, pc_reg, gnt, rv, rdata, fl, rdy);
        #1;
        launch_e = !m_req && !m_wait && ce && (m_q.size() < DEPTH) && !fl;
        chk("rnd.pc_stall", bus.pc_stall, !launch_e);
        chk("rnd.imem_req", bus.imem_req, m_req);
        if (m_req) chk("rnd.imem_addr", bus.imem_addr, m_addr);
        chk("rnd.id_valid", bus.id_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
          chk("rnd.id_pc", bus.id_pc, m_q[0].pc);
          chk("rnd.id_inst", bus.id_inst, m_q[0].inst);
        end
        @(posedge clk);
        pop_e  = (m_q.size() != 0) && rdy;
        push_e = m_wait && rv && !m_kill && !fl;
        if (fl) m_q.delete();
        else begin
          if (pop_e) void'(m_q.pop_front());
          if (push_e) begin
            e.pc = m_addr; e.inst = rdata;
            m_q.push_back(e);
          end
        end
        r_old = m_req; w_old = m_wait;
        if (r_old) begin
          if (gnt) begin m_req = 0; m_wait = 1; m_kill = fl; end
          else if (fl) m_req = 0;
        end
        if (w_old) begin
          if (rv) m_wait = 0;
          else if (fl) m_kill = 1;
        end
        if (launch_e) begin m_req = 1; m_addr = pc_reg; end
        if (fl) pc_reg = 32'($urandom_range(0, 1023)) << 2;
        else if (launch_e) pc_reg = pc_reg + 32'd4;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
